pixel_bus_packer: RTL

- Producer side of the dot-product pixel bus. Accepts a serial pixel stream with a valid/ready handshake and packs it into BUS_WIDTH-slot wide words.
- Presents each packed word on a Pixels bus to the dot-product engine, which pulses bus_take when it has captured the word.
- Two banks in ping-pong: one bank fills while the other is held for the consumer. Images shorter than a whole number of words are zero-padded.

---
 rtl/pixel_bus_packer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pixel_bus_packer.sv
// Packs a serial valid/ready pixel stream into BUS_WIDTH-slot words using two ping-pong banks.
// Define PACKER_BIAS_PIX_EN to preload slot 0 of every image with BIAS_VALUE.
module pixel_bus_packer #(
  parameter int unsigned PIXEL_SIZE = 10,
  parameter int unsigned BUS_WIDTH  = 196,
  parameter int unsigned BIAS_VALUE = 1023,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                             clk,
  input  logic                             GlobalReset_n,
  input  logic [PIXEL_SIZE-1:0]            pix_data,
  input  logic                             pix_valid,
  input  logic                             pix_last,
  output logic                             pix_ready,
  output logic [BUS_WIDTH*PIXEL_SIZE-1:0]  Pixels,
  output logic                             bus_valid,
  output logic                             bus_last,
  output logic [IDX_W-1:0]                 bus_index,
  input  logic                             bus_take
);

  localparam int unsigned WORD_W = BUS_WIDTH * PIXEL_SIZE;
  localparam int unsigned FILL_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
`ifdef PACKER_BIAS_PIX_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam logic [PIXEL_SIZE-1:0] BIAS_PIX   = PIXEL_SIZE'(BIAS_VALUE);
  localparam logic [WORD_W-1:0]     EMPTY_WORD = BIAS_EN ? WORD_W'(BIAS_PIX) : '0;
  localparam logic [FILL_W-1:0]     START_FILL = FILL_W'(BIAS_EN);
  localparam logic [FILL_W-1:0]     LAST_SLOT  = FILL_W'(BUS_WIDTH - 1);

  typedef logic [WORD_W-1:0] word_t;

  word_t             bank_q [2];
  word_t             bank_d [2];
  logic [IDX_W-1:0]  idx_q  [2];
  logic [IDX_W-1:0]  idx_d  [2];
  logic [1:0]        full_q, full_d;
  logic [1:0]        last_q, last_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
  logic              accept, take, complete;

  // Handshake and bus view depend on registered bank state only.
  always_comb begin
    pix_ready = ~full_q[wr_bank_q];
    bus_valid = full_q[rd_bank_q];
    Pixels    = bus_valid ? bank_q[rd_bank_q] : '0;
    bus_last  = bus_valid & last_q[rd_bank_q];
    bus_index = bus_valid ? idx_q[rd_bank_q] : '0;
  end

  always_comb begin
    bank_d     = bank_q;
    idx_d      = idx_q;
    full_d     = full_q;
    last_d     = last_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    fill_cnt_d = fill_cnt_q;
    word_cnt_d = word_cnt_q;

    accept   = pix_valid & ~full_q[wr_bank_q];
    take     = bus_take & full_q[rd_bank_q];
    complete = accept & (pix_last | (fill_cnt_q == LAST_SLOT));

    // A taken bank is recycled immediately; ping-pong order keeps it apart from the write bank.
    if (take) begin
      bank_d[rd_bank_q] = EMPTY_WORD;
      idx_d[rd_bank_q]  = '0;
      full_d[rd_bank_q] = 1'b0;
      last_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      for (int k = 0; k < BUS_WIDTH; k++) begin
        if (fill_cnt_q == FILL_W'(k)) begin
          bank_d[wr_bank_q][k*PIXEL_SIZE +: PIXEL_SIZE] = pix_data;
        end
      end
    end

    if (complete) begin
      full_d[wr_bank_q] = 1'b1;
      last_d[wr_bank_q] = pix_last;
      idx_d[wr_bank_q]  = word_cnt_q;
      wr_bank_d         = ~wr_bank_q;
      fill_cnt_d        = pix_last ? START_FILL : '0;
      word_cnt_d        = pix_last ? '0 : word_cnt_q + IDX_W'(1);
    end else if (accept) begin
      fill_cnt_d = fill_cnt_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      bank_q[0]  <= EMPTY_WORD;
      bank_q[1]  <= EMPTY_WORD;
      idx_q[0]   <= '0;
      idx_q[1]   <= '0;
      full_q     <= '0;
      last_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      fill_cnt_q <= START_FILL;
      word_cnt_q <= '0;
    end else begin
      bank_q     <= bank_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      last_q     <= last_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      fill_cnt_q <= fill_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
